// File: rtl/wake_sequencer_if.sv
// Pin-side bundle of the wake sequencer: VAD, DFE strobe, detection in; enables, gate, wake out.
// WAKE_COUNT_EN adds the wake_count_o debug counter to the bundle.
interface wake_sequencer_if;
    logic        vad_i;
    logic        dfe_valid_i;
    logic        wake_det_i;
    logic        pipeline_en_o;
    logic        flush_o;
    logic        dfe_gate_o;
    logic        wake_o;
    logic [2:0]  state_o;
`ifdef WAKE_COUNT_EN
    logic [15:0] wake_count_o;
`endif

    modport slave (
        input  vad_i,
        input  dfe_valid_i,
        input  wake_det_i,
        output pipeline_en_o,
        output flush_o,
        output dfe_gate_o,
        output wake_o,
        output state_o
`ifdef WAKE_COUNT_EN
        , output wake_count_o
`endif
    );

    modport master (
        output vad_i,
        output dfe_valid_i,
        output wake_det_i,
        input  pipeline_en_o,
        input  flush_o,
        input  dfe_gate_o,
        input  wake_o,
        input  state_o
`ifdef WAKE_COUNT_EN
        , input wake_count_o
`endif
    );
endinterface

// File: rtl/wake_sequencer.sv
// Power/wake control FSM around the VAD pin: warm-up, active, hangover, wake pulse, cooldown.
// Optional saturating wake-event counter under WAKE_COUNT_EN.
module wake_sequencer #(
    parameter int unsigned WARMUP_SAMPLES  = 16,
    parameter int unsigned HANG_CYCLES     = 16384,
    parameter int unsigned WAKE_CYCLES     = 1024,
    parameter int unsigned COOLDOWN_CYCLES = 4096,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    wake_sequencer_if.slave  bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WARMUP   = 3'd1;
    localparam logic [2:0] S_ACTIVE   = 3'd2;
    localparam logic [2:0] S_HANG     = 3'd3;
    localparam logic [2:0] S_WAKE     = 3'd4;
    localparam logic [2:0] S_COOLDOWN = 3'd5;

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_SAMPLES - 1);
    localparam logic [CNT_W-1:0] HANG_LAST = CNT_W'(HANG_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    logic             sync1_reg;
    logic             sync2_reg;
    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             flush_reg;
    logic             flush_next;
    logic             wake_reg;
    logic             wake_next;
    logic             vad_s;

    assign vad_s = sync2_reg;

    // vad_i is asynchronous to clk_i; two flops before the FSM sees it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= bus.vad_i;
            sync2_reg <= sync1_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        flush_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (vad_s) begin
                    state_next = S_WARMUP;
                    cnt_next   = CNT_ZERO;
                    flush_next = 1'b1;
                end
            end
            S_WARMUP: begin
                if (!vad_s) begin
                    state_next = S_IDLE;
                end else if (bus.dfe_valid_i) begin
                    if (cnt_reg == WARM_LAST) begin
                        state_next = S_ACTIVE;
                        cnt_next   = CNT_ZERO;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                // A detection outranks a simultaneous VAD drop.
                if (bus.wake_det_i) begin
                    state_next = S_WAKE;
                    cnt_next   = WAKE_LAST;
                end else if (!vad_s) begin
                    state_next = S_HANG;
                    cnt_next   = HANG_LAST;
                end
            end
            S_HANG: begin
                if (bus.wake_det_i) begin
                    state_next = S_WAKE;
                    cnt_next   = WAKE_LAST;
                end else if (vad_s) begin
                    state_next = S_ACTIVE;
                end else if (cnt_reg == CNT_ZERO) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_WAKE: begin
                if (cnt_reg == CNT_ZERO) begin
                    state_next = S_COOLDOWN;
                    cnt_next   = COOL_LAST;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (cnt_reg == CNT_ZERO) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = CNT_ZERO;
            end
        endcase
        wake_next = (state_next == S_WAKE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
            cnt_reg   <= CNT_ZERO;
            flush_reg <= 1'b0;
            wake_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            flush_reg <= flush_next;
            wake_reg  <= wake_next;
        end
    end

    assign bus.pipeline_en_o = (state_reg == S_WARMUP) || (state_reg == S_ACTIVE) ||
                               (state_reg == S_HANG);
    assign bus.dfe_gate_o    = bus.dfe_valid_i &&
                               ((state_reg == S_ACTIVE) || (state_reg == S_HANG));
    assign bus.flush_o       = flush_reg;
    assign bus.wake_o        = wake_reg;
    assign bus.state_o       = state_reg;

`ifdef WAKE_COUNT_EN
    logic [15:0] wake_count_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wake_count_reg <= 16'h0000;
        end else if ((state_next == S_WAKE) && (state_reg != S_WAKE) &&
                     (wake_count_reg != 16'hFFFF)) begin
            wake_count_reg <= wake_count_reg + 16'h0001;
        end
    end

    assign bus.wake_count_o = wake_count_reg;
`endif
endmodule

// File: tb/tb_wake_sequencer.sv
// Randomized scoreboard bench for wake_sequencer against a phase/elapsed-time reference model.
module tb_wake_sequencer;
    localparam int P_WARM = 4;
    localparam int P_HANG = 8;
    localparam int P_WAKE = 5;
    localparam int P_COOL = 6;
    localparam int N_CYC  = 5000;

    localparam int PH_IDLE = 0, PH_WARMUP = 1, PH_ACTIVE = 2, PH_HANG = 3,
                   PH_WAKE = 4, PH_COOL = 5;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  st;
        logic        wake;
        logic        flush;
        logic        pen;
        logic        gate;
        logic [15:0] count;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i;
    wake_sequencer_if bus ();

    wake_sequencer #(
        .WARMUP_SAMPLES (P_WARM),
        .HANG_CYCLES    (P_HANG),
        .WAKE_CYCLES    (P_WAKE),
        .COOLDOWN_CYCLES(P_COOL),
        .CNT_W          (16)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: which phase we are in, how long we have been there,
    // how many warm-up samples have been swallowed, and the VAD seen 1 and 2 cycles ago.
    int   m_phase, m_time, m_samples, m_count;
    bit   m_flush, m_vad_d1, m_vad_d2;

    task automatic model_reset();
        m_phase = PH_IDLE; m_time = 0; m_samples = 0; m_count = 0;
        m_flush = 0; m_vad_d1 = 0; m_vad_d2 = 0;
    endtask

    function automatic exp_t model_outputs(int cyc, bit dfe);
        exp_t e;
        e.cyc   = cyc;
        e.st    = 3'(m_phase);
        e.wake  = (m_phase == PH_WAKE);
        e.flush = m_flush;
        e.pen   = (m_phase == PH_WARMUP) || (m_phase == PH_ACTIVE) || (m_phase == PH_HANG);
        e.gate  = dfe && ((m_phase == PH_ACTIVE) || (m_phase == PH_HANG));
        e.count = 16'(m_count);
        return e;
    endfunction

    task automatic model_step(bit rst, bit vad, bit dfe, bit wdet);
        int  nxt;
        bit  vs;
        if (rst) begin
            model_reset();
            return;
        end
        vs  = m_vad_d2;
        nxt = m_phase;
        m_flush = 0;
        case (m_phase)
            PH_IDLE:   if (vs) begin nxt = PH_WARMUP; m_samples = 0; m_flush = 1; end
            PH_WARMUP: if (!vs) nxt = PH_IDLE;
                       else if (dfe) begin
                           m_samples++;
                           if (m_samples == P_WARM) nxt = PH_ACTIVE;
                       end
            PH_ACTIVE: if (wdet) nxt = PH_WAKE; else if (!vs) nxt = PH_HANG;
            PH_HANG:   if (wdet) nxt = PH_WAKE;
                       else if (vs) nxt = PH_ACTIVE;
                       else if (m_time + 1 == P_HANG) nxt = PH_IDLE;
            PH_WAKE:   if (m_time + 1 == P_WAKE) nxt = PH_COOL;
            PH_COOL:   if (m_time + 1 == P_COOL) nxt = PH_IDLE;
            default:   nxt = PH_IDLE;
        endcase
        if (nxt == PH_WAKE && m_phase != PH_WAKE && m_count < 16'hFFFF) m_count++;
        m_time   = (nxt != m_phase) ? 0 : m_time + 1;
        m_phase  = nxt;
        m_vad_d2 = m_vad_d1;
        m_vad_d1 = vad;
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare with the queued expectation.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [6:0] act, req;
            e   = exp_q.pop_front();
            act = {bus.state_o, bus.wake_o, bus.flush_o, bus.pipeline_en_o, bus.dfe_gate_o};
            req = {e.st, e.wake, e.flush, e.pen, e.gate};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL outputs cycle %0d: actual st=%0d wake=%b flush=%b pen=%b gate=%b, required st=%0d wake=%b flush=%b pen=%b gate=%b",
                         e.cyc, act[6:4], act[3], act[2], act[1], act[0],
                         req[6:4], req[3], req[2], req[1], req[0]);
            end
`ifdef WAKE_COUNT_EN
            checks++;
            if (bus.wake_count_o !== e.count) begin
                errors++;
                $display("FAIL wake_count cycle %0d: actual %0d required %0d",
                         e.cyc, bus.wake_count_o, e.count);
            end
`endif
        end
    end

    initial begin
        bit vad, dfe, wdet, rst;
        int vad_left, rst_left, n_wake, n_flush, n_rst;
        exp_t e;
        vad = 0; vad_left = 40; rst_left = 0;
        n_wake = 0; n_flush = 0; n_rst = 0;
        rst_i = 1'b1;
        bus.vad_i = 1'b0; bus.dfe_valid_i = 1'b0; bus.wake_det_i = 1'b0;
        @(posedge clk_i);
        model_reset();
        for (int k = 0; k < N_CYC; k++) begin
            @(posedge clk_i);
            #1;
            if (k < 3) begin
                rst = 1; vad = 0; dfe = k[0];
            end else begin
                if (rst_left > 0) rst_left--;
                else if ($urandom_range(0, 179) == 0) rst_left = $urandom_range(1, 3);
                rst = (rst_left > 0);
                if (vad_left == 0) begin
                    vad      = ~vad;
                    vad_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2)
                                                           : $urandom_range(3, 30);
                end else begin
                    vad_left--;
                end
                dfe = ($urandom_range(0, 2) == 0);
            end
            wdet = (k >= 3) && ($urandom_range(0, 11) == 0);
            rst_i = rst; bus.vad_i = vad; bus.dfe_valid_i = dfe; bus.wake_det_i = wdet;
            e = model_outputs(k, dfe);
            exp_q.push_back(e);
            if (e.wake)  n_wake++;
            if (e.flush) n_flush++;
            if (rst)     n_rst++;
            model_step(rst, vad, dfe, wdet);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0; bus.vad_i = 1'b0; bus.dfe_valid_i = 1'b0; bus.wake_det_i = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: actual %0d pending, required 0", exp_q.size());
        end
        $display("coverage: wake cycles=%0d flushes=%0d reset cycles=%0d", n_wake, n_flush, n_rst);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
